ram_sdp_init: RTL and testbench

- Parametrised simple dual-port RAM: one write port and one independent read port.
- Adds per-lane write masking, selectable async or sync read, a read-during-write policy and a built-in clear sequencer.
- The clear sequencer fills every location with a fixed value after reset or on request.
- Generic storage primitive for buffers, register files and lookup tables across the design.

---
 rtl/ram_sdp_init.sv | 126 ++++++++++++
 tb/tb_ram_sdp_init.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sdp_init.sv
// Simple dual-port RAM with per-lane write masking, async or sync read and a
// clear sequencer that fills every word with init_value after reset or on request.
//
// state | meaning
// CLEAR | sequencer writes init_value to mem[cptr]; user ports ignored, busy=1
// IDLE  | normal operation; clear=1 re-enters CLEAR from address 0
module ram_sdp_init #(
    parameter int                length     = 8,
    parameter int                locations  = 16,
    parameter int                lane       = 4,
    parameter int                read_mode  = 1,
    parameter int                rdw_mode   = 0,
    parameter logic [length-1:0] init_value = '0,
    localparam int               AW         = (locations > 1) ? $clog2(locations) : 1,
    localparam int               MW         = length / lane
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [length-1:0] wdata,
    input  logic [MW-1:0]     wmask,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [length-1:0] rdata,
    output logic              rvalid
);

    typedef enum logic {CLEAR = 1'b0, IDLE = 1'b1} state_t;

    localparam logic [AW:0]   LOC  = (AW+1)'(locations);
    localparam logic [AW-1:0] LAST = AW'(locations - 1);

    state_t            state;
    logic [AW-1:0]     cptr;
    logic [length-1:0] mem [locations];
    logic              waddr_ok;
    logic              raddr_ok;
    logic              wr_en;
    logic [length-1:0] wmerge;

    assign waddr_ok = ({1'b0, waddr} < LOC);
    assign raddr_ok = ({1'b0, raddr} < LOC);
    assign wr_en    = we && !busy && waddr_ok;

    // Full-word view of a masked write: new lanes where wmask is set, old elsewhere.
    always_comb begin
        wmerge = mem[waddr];
        for (int i = 0; i < MW; i++) begin
            if (wmask[i]) begin
                wmerge[i*lane +: lane] = wdata[i*lane +: lane];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
            cptr  <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    if (cptr == LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cptr  <= '0;
                    end else begin
                        cptr <= cptr + AW'(1);
                    end
                end
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cptr  <= '0;
                    end
                end
            endcase
        end
    end

    // The array itself carries no reset; the clear sequence initialises it.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cptr] <= init_value;
        end else if (wr_en) begin
            mem[waddr] <= wmerge;
        end
    end

    generate
        if (read_mode == 1) begin : g_sync
            logic [length-1:0] rword;

            always_comb begin
                rword = '0;
                if (raddr_ok) begin
                    if (rdw_mode == 1 && wr_en && waddr == raddr) begin
                        rword = wmerge;
                    end else begin
                        rword = mem[raddr];
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata  <= '0;
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= re && !busy;
                    if (re && !busy) begin
                        rdata <= rword;
                    end
                end
            end
        end else begin : g_async
            assign rdata  = raddr_ok ? mem[raddr] : '0;
            assign rvalid = re && !busy;
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_init.sv
// Bench for ram_sdp_init: four instances (sync old-data, sync write-first,
// 12-deep sync, async) share one stimulus stream; reads are scoreboarded.
module tb_ram_sdp_init;

    localparam int          W  = 8;
    localparam int          AW = 4;
    localparam int          MW = 2;
    localparam logic [7:0]  IV = 8'hA5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [W-1:0]  wdata = '0;
    logic [MW-1:0] wmask = '0;

    logic          busy0, busy1, busy2, busy3;
    logic          rvalid0, rvalid1, rvalid2, rvalid3;
    logic [W-1:0]  rdata0, rdata1, rdata2, rdata3;

    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    q0[$];
    logic [7:0]    q1[$];
    logic [7:0]    q2[$];
    logic [7:0]    model [16];
    logic [7:0]    exp2  [12];

    always #5 clk = ~clk;

    ram_sdp_init #(.length(8), .locations(16), .lane(4), .read_mode(1), .rdw_mode(0), .init_value(IV)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy0), .we(we), .waddr(waddr), .wdata(wdata),
        .wmask(wmask), .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0));
    ram_sdp_init #(.length(8), .locations(16), .lane(4), .read_mode(1), .rdw_mode(1), .init_value(IV)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy1), .we(we), .waddr(waddr), .wdata(wdata),
        .wmask(wmask), .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1));
    ram_sdp_init #(.length(8), .locations(12), .lane(4), .read_mode(1), .rdw_mode(0), .init_value(IV)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy2), .we(we), .waddr(waddr), .wdata(wdata),
        .wmask(wmask), .re(re), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2));
    ram_sdp_init #(.length(8), .locations(16), .lane(4), .read_mode(0), .rdw_mode(0), .init_value(IV)) dut3 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .busy(busy3), .we(we), .waddr(waddr), .wdata(wdata),
        .wmask(wmask), .re(re), .raddr(raddr), .rdata(rdata3), .rvalid(rvalid3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt0, cnt2;
        repeat (3) tick();
        n_vec++;
        if (busy0 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h00 || busy2 !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: busy=%b rvalid=%b rdata=%h busy2=%b, want 1 0 00 1",
                     busy0, rvalid0, rdata0, busy2);
        end
        rst_n = 1'b1;
        cnt0 = 0;
        cnt2 = 0;
        for (int k = 1; k <= 40 && (busy0 || busy2); k++) begin
            tick();
            if (!busy0 && cnt0 == 0) cnt0 = k;
            if (!busy2 && cnt2 == 0) cnt2 = k;
        end
        n_vec++;
        if (cnt0 != 16) begin
            n_err++;
            $display("FAIL reset_busy_len16: busy cycles=%0d, want 16", cnt0);
        end
        n_vec++;
        if (cnt2 != 12) begin
            n_err++;
            $display("FAIL reset_busy_len12: busy cycles=%0d, want 12", cnt2);
        end
    endtask

    task automatic test_readback_all(input string tag);
        logic [7:0] e;
        for (int a = 0; a < 16; a++) begin
            re = 1'b1;
            raddr = AW'(a);
            q0.push_back(model[a]);
            q1.push_back(model[a]);
            tick();
            n_vec++;
            if (rvalid0 === 1'b1 && q0.size() > 0) begin
                e = q0.pop_front();
                if (rdata0 !== e) begin
                    n_err++;
                    $display("FAIL %s_dut0 addr %0d: got %h, want %h", tag, a, rdata0, e);
                end
            end else begin
                n_err++;
                $display("FAIL %s_dut0_rvalid addr %0d: rvalid=%b, want 1", tag, a, rvalid0);
            end
            n_vec++;
            if (rvalid1 === 1'b1 && q1.size() > 0) begin
                e = q1.pop_front();
                if (rdata1 !== e) begin
                    n_err++;
                    $display("FAIL %s_dut1 addr %0d: got %h, want %h", tag, a, rdata1, e);
                end
            end else begin
                n_err++;
                $display("FAIL %s_dut1_rvalid addr %0d: rvalid=%b, want 1", tag, a, rvalid1);
            end
        end
        re = 1'b0;
        tick();
        n_vec++;
        if (rvalid0 !== 1'b0 || q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: rvalid=%b pending=%0d/%0d, want 0 0/0", tag, rvalid0, q0.size(), q1.size());
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic test_mask_write();
        logic [7:0] e;
        we = 1'b1; waddr = 4'd3; wdata = 8'h3C; wmask = 2'b01;
        tick();
        model[3] = 8'hAC;
        exp2[3]  = 8'hAC;
        waddr = 4'd4; wdata = 8'h00; wmask = 2'b00;
        tick();
        we = 1'b0; wmask = 2'b11;
        re = 1'b1; raddr = 4'd3;
        q0.push_back(8'hAC);
        #1;
        n_vec++;
        if (rvalid3 !== 1'b1 || rdata3 !== 8'hAC) begin
            n_err++;
            $display("FAIL mask_async: rvalid=%b rdata=%h, want 1 ac", rvalid3, rdata3);
        end
        tick();
        re = 1'b0;
        n_vec++;
        if (rvalid0 === 1'b1 && q0.size() > 0) begin
            e = q0.pop_front();
            if (rdata0 !== e) begin
                n_err++;
                $display("FAIL mask_sync_data: got %h, want %h", rdata0, e);
            end
        end else begin
            n_err++;
            $display("FAIL mask_sync_rvalid: rvalid=%b, want 1", rvalid0);
        end
        tick();
        n_vec++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'hAC) begin
            n_err++;
            $display("FAIL mask_rvalid_one_cycle: rvalid=%b rdata=%h, want 0 ac", rvalid0, rdata0);
        end
    endtask

    task automatic test_rdw();
        logic [7:0] e;
        we = 1'b1; waddr = 4'd7; wdata = 8'h5A; wmask = 2'b11;
        re = 1'b1; raddr = 4'd7;
        q0.push_back(8'hA5);
        q1.push_back(8'h5A);
        for (int c = 0; c < 2; c++) begin
            tick();
            if (c == 0) begin
                we = 1'b0;
                model[7] = 8'h5A;
                exp2[7]  = 8'h5A;
                q0.push_back(8'h5A);
                q1.push_back(8'h5A);
            end else begin
                re = 1'b0;
            end
            n_vec++;
            if (rvalid0 === 1'b1 && q0.size() > 0) begin
                e = q0.pop_front();
                if (rdata0 !== e) begin
                    n_err++;
                    $display("FAIL rdw_old_%0d: got %h, want %h", c, rdata0, e);
                end
            end else begin
                n_err++;
                $display("FAIL rdw_old_rvalid_%0d: rvalid=%b, want 1", c, rvalid0);
            end
            n_vec++;
            if (rvalid1 === 1'b1 && q1.size() > 0) begin
                e = q1.pop_front();
                if (rdata1 !== e) begin
                    n_err++;
                    $display("FAIL rdw_new_%0d: got %h, want %h", c, rdata1, e);
                end
            end else begin
                n_err++;
                $display("FAIL rdw_new_rvalid_%0d: rvalid=%b, want 1", c, rvalid1);
            end
        end
        tick();
    endtask

    task automatic test_bounds();
        logic [7:0] e;
        we = 1'b1; waddr = 4'd13; wdata = 8'h77; wmask = 2'b11;
        tick();
        we = 1'b0;
        model[13] = 8'h77;
        re = 1'b1; raddr = 4'd13;
        tick();
        re = 1'b0;
        n_vec++;
        if (rvalid2 !== 1'b1 || rdata2 !== 8'h00) begin
            n_err++;
            $display("FAIL oob_read: rvalid=%b rdata=%h, want 1 00", rvalid2, rdata2);
        end
        n_vec++;
        if (rdata0 !== 8'h77) begin
            n_err++;
            $display("FAIL inbound_16deep: got %h, want 77", rdata0);
        end
        for (int a = 0; a < 12; a++) begin
            re = 1'b1;
            raddr = AW'(a);
            q2.push_back(exp2[a]);
            tick();
            n_vec++;
            if (rvalid2 === 1'b1 && q2.size() > 0) begin
                e = q2.pop_front();
                if (rdata2 !== e) begin
                    n_err++;
                    $display("FAIL oob_neighbours addr %0d: got %h, want %h", a, rdata2, e);
                end
            end else begin
                n_err++;
                $display("FAIL oob_neighbours_rvalid addr %0d: rvalid=%b, want 1", a, rvalid2);
            end
        end
        re = 1'b0;
        tick();
    endtask

    task automatic test_clear_busy();
        int cnt;
        clear = 1'b1;
        we = 1'b1; waddr = 4'd2; wdata = 8'h11; wmask = 2'b11;
        tick();
        clear = 1'b0;
        we = 1'b0;
        n_vec++;
        if (busy0 !== 1'b1 || rvalid0 !== 1'b0) begin
            n_err++;
            $display("FAIL clear_start: busy=%b rvalid=%b, want 1 0", busy0, rvalid0);
        end
        cnt = 0;
        for (int k = 0; k < 40 && busy0; k++) begin
            cnt++;
            clear = (k == 5);
            we = 1'b1; waddr = 4'd5; wdata = 8'hFF; wmask = 2'b11;
            re = 1'b1; raddr = 4'd5;
            #1;
            n_vec++;
            if (rvalid3 !== 1'b0) begin
                n_err++;
                $display("FAIL busy_async_rvalid cycle %0d: got %b, want 0", k, rvalid3);
            end
            tick();
            n_vec++;
            if (rvalid0 !== 1'b0) begin
                n_err++;
                $display("FAIL busy_sync_rvalid cycle %0d: got %b, want 0", k, rvalid0);
            end
        end
        clear = 1'b0; we = 1'b0; re = 1'b0;
        n_vec++;
        if (cnt != 16) begin
            n_err++;
            $display("FAIL clear_busy_len: busy cycles=%0d, want 16", cnt);
        end
        for (int a = 0; a < 16; a++) model[a] = IV;
    endtask

    task automatic test_async();
        we = 1'b1; waddr = 4'd9; wdata = 8'h3C; wmask = 2'b11;
        re = 1'b1; raddr = 4'd9;
        #1;
        n_vec++;
        if (rvalid3 !== 1'b1 || rdata3 !== 8'hA5) begin
            n_err++;
            $display("FAIL async_pre_write: rvalid=%b rdata=%h, want 1 a5", rvalid3, rdata3);
        end
        tick();
        we = 1'b0;
        model[9] = 8'h3C;
        n_vec++;
        if (rdata3 !== 8'h3C) begin
            n_err++;
            $display("FAIL async_post_write: got %h, want 3c", rdata3);
        end
        #2 raddr = 4'd4;
        #1;
        n_vec++;
        if (rdata3 !== model[4]) begin
            n_err++;
            $display("FAIL async_raddr_follow: got %h, want %h", rdata3, model[4]);
        end
        re = 1'b0;
        #1;
        n_vec++;
        if (rvalid3 !== 1'b0) begin
            n_err++;
            $display("FAIL async_rvalid_re0: got %b, want 0", rvalid3);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (busy3 !== 1'b1 || rvalid0 !== 1'b0 || rdata0 !== 8'h00) begin
            n_err++;
            $display("FAIL midclear_reset_state: busy=%b rvalid=%b rdata=%h, want 1 0 00", busy3, rvalid0, rdata0);
        end
        #2 rst_n = 1'b1;
        cnt = 0;
        for (int k = 1; k <= 40 && busy3; k++) begin
            tick();
            if (!busy3) cnt = k;
        end
        n_vec++;
        if (cnt != 16) begin
            n_err++;
            $display("FAIL midclear_restart_len: busy cycles=%0d, want 16", cnt);
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) model[a] = IV;
        for (int a = 0; a < 12; a++) exp2[a] = IV;
        test_reset();
        test_readback_all("init");
        test_mask_write();
        test_rdw();
        test_bounds();
        test_clear_busy();
        test_readback_all("post_clear");
        test_async();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
